register_file_param: RTL and testbench
======================================

// Module: register_file_param
// PURPOSE
//  Parametrised 2-read/1-write register file for the CPU datapath. Synchronous, registered reads.
//  Optional write-to-read bypass and hardwired-zero register 0. Per-register busy scoreboard
//  for pending writes. Sequencer clears the whole array without a reset.
// PARAMETERS
//  DATA_WIDTH  32  width of each register and of the data ports
//  ADDR_WIDTH  5   register address width; DEPTH = 2**ADDR_WIDTH (localparam)
//  ZERO_REG    1   1: reg 0 always reads 0, ignores writes, never busy; 0: reg 0 is ordinary
//  BYPASS      1   1: same-edge write is forwarded to a matching read; 0: read returns old value
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           asynchronous reset, active-high
//  regs       in   ADDR_WIDTH  read address, port 1
//  regt       in   ADDR_WIDTH  read address, port 2
//  reg1       out  DATA_WIDTH  read data, port 1 (registered)
//  reg2       out  DATA_WIDTH  read data, port 2 (registered)
//  busy1      out  1           busy flag of regs (registered with reg1)
//  busy2      out  1           busy flag of regt (registered with reg2)
//  regWrite   in   1           write enable
//  regd       in   ADDR_WIDTH  write address
//  dataWrite  in   DATA_WIDTH  write data
//  reserve    in   1           mark rsvAddr busy (pending producer issued)
//  rsvAddr    in   ADDR_WIDTH  register to reserve
//  clearReq   in   1           start array clear (pulse)
//  clearBusy  out  1           high while clear sequence runs
//  clearDone  out  1           one-cycle pulse when clear completes
// BEHAVIOUR
//  Reset (rst=1, async): all array entries 0; busy bits 0; reg1/reg2/busy1/busy2 0.
//   State IDLE, clear counter 0, clearBusy=0, clearDone=0. Effective immediately; no clk needed.
//  Reads: latency 1. At edge k, reg1/busy1 load the entry addressed by regs at edge k
//   (same for reg2/busy2 with regt). Outputs hold between edges.
//  Writes: at an edge with regWrite=1 in IDLE, entry[regd] <= dataWrite and busy[regd] <= 0.
//  Bypass (BYPASS=1): write and read address match at the same edge -> reg1 gets dataWrite,
//   busy1 gets the post-edge busy value. BYPASS=0: reg1/busy1 get the pre-edge values.
//   Both ports bypass independently.
//  Reserve: at an edge with reserve=1 in IDLE, busy[rsvAddr] <= 1. Same edge, same address
//   as a write: data is written and busy ends 1 (reserve wins).
//  ZERO_REG=1: reads of address 0 return 0 with busy 0, including via bypass.
//   Writes and reserves to 0 are dropped.
//  FSM states IDLE, CLEAR:
//   IDLE --clearReq=1--> CLEAR, counter <= 0, clearBusy <= 1.
//   CLEAR: each edge entry[counter] <= 0, busy[counter] <= 0, counter += 1.
//   CLEAR: after writing index DEPTH-1 -> IDLE, clearBusy <= 0, clearDone <= 1 for one cycle.
//   Clear therefore occupies exactly DEPTH cycles.
//   CLEAR: regWrite, reserve and clearReq are ignored (dropped, not queued).
//   CLEAR: reads continue and return current contents; no bypass of clear zeroes.
//   clearReq held high in IDLE restarts a clear on the cycle after clearDone.
//  Counter is ADDR_WIDTH bits and wraps to 0 at the end of the clear; no extra idle cycle.
//  rst asserted mid-clear: immediate return to IDLE with all state as at reset; no clearDone pulse.
//  Out-of-range addresses cannot occur (full decode, DEPTH = 2**ADDR_WIDTH).
// TESTING
//  T1 reset: rst=1 mid-run -> reg1=reg2=0, busy1=busy2=0, clearBusy=0 without a clk edge;
//     read all 32 regs -> 0.
//  T2 write/read: write 0xDEADBEEF to r5, next cycle regs=5 -> reg1=0xDEADBEEF one edge later.
//     regt=5 gives the same on reg2.
//  T3 bypass: r7=0x11, same edge regWrite r7=0x22 with regs=7.
//     BYPASS=1 -> reg1=0x22; BYPASS=0 -> reg1=0x11, then 0x22 on the following read.
//  T4 zero reg (ZERO_REG=1): write 0xFFFFFFFF to r0 plus reserve r0 -> reads of r0 give 0, busy 0.
//  T5 scoreboard: reserve r9 -> busy1=1 on read of r9.
//     Write r9=0x5 -> busy1=0, reg1=0x5. Reserve+write r9 same edge -> busy ends 1.
//  T6 clear: fill r1..r31, pulse clearReq -> clearBusy high 32 cycles, regWrite ignored.
//     clearDone pulses once, all reads 0. Repeat with rst at cycle 10 of the clear
//     -> IDLE, no clearDone.

Source files
------------

// File: rtl/register_file_param.sv
// register_file_param: 2-read/1-write register file with registered reads,
// busy scoreboard, optional bypass/zero register and a sequenced array clear.
module register_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0] regt,
  output logic [DATA_WIDTH-1:0] reg1,
  output logic [DATA_WIDTH-1:0] reg2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] regd,
  input  logic [DATA_WIDTH-1:0] dataWrite,
  input  logic                  reserve,
  input  logic [ADDR_WIDTH-1:0] rsvAddr,
  input  logic                  clearReq,
  output logic                  clearBusy,
  output logic                  clearDone
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]        busy;
  logic [DEPTH-1:0]        busy_nxt;

  logic                    idle;
  logic                    wr_en;
  logic                    rsv_en;
  logic [DATA_WIDTH-1:0]   rd1_d;
  logic [DATA_WIDTH-1:0]   rd2_d;
  logic                    rd1_b;
  logic                    rd2_b;

  function automatic logic is_zero(
    input logic [ADDR_WIDTH-1:0] a
  );
    return ZERO_REG && (a == '0);
  endfunction

  assign idle   = (state == IDLE);
  assign wr_en  = idle && regWrite && !is_zero(regd);
  assign rsv_en = idle && reserve && !is_zero(rsvAddr);

  // Reserve is applied last so it wins over a same-edge write.
  always_comb begin
    busy_nxt = busy;
    if (!idle)  busy_nxt[cnt]     = 1'b0;
    if (wr_en)  busy_nxt[regd]    = 1'b0;
    if (rsv_en) busy_nxt[rsvAddr] = 1'b1;
  end

  always_comb begin
    rd1_d = mem[regs];
    rd1_b = busy[regs];
    if (BYPASS && wr_en && (regd == regs)) begin
      rd1_d = dataWrite;
      rd1_b = busy_nxt[regs];
    end
    if (is_zero(regs)) begin
      rd1_d = '0;
      rd1_b = 1'b0;
    end
  end

  always_comb begin
    rd2_d = mem[regt];
    rd2_b = busy[regt];
    if (BYPASS && wr_en && (regd == regt)) begin
      rd2_d = dataWrite;
      rd2_b = busy_nxt[regt];
    end
    if (is_zero(regt)) begin
      rd2_d = '0;
      rd2_b = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      if (!idle) begin
        mem[cnt] <= '0;
      end else if (wr_en) begin
        mem[regd] <= dataWrite;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg1  <= '0;
      reg2  <= '0;
      busy1 <= 1'b0;
      busy2 <= 1'b0;
    end else begin
      reg1  <= rd1_d;
      reg2  <= rd2_d;
      busy1 <= rd1_b;
      busy2 <= rd2_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      clearBusy <= 1'b0;
      clearDone <= 1'b0;
    end else begin
      clearDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clearReq) begin
            state     <= CLEAR;
            cnt       <= '0;
            clearBusy <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + ADDR_WIDTH'(1);
          if (cnt == LAST) begin
            state     <= IDLE;
            clearBusy <= 1'b0;
            clearDone <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param: randomized + directed stimulus, reference model
// feeding a scoreboard queue that a cycle monitor drains.
module tb_register_file_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] regs, regt, regd, rsvAddr;
  logic [DW-1:0] reg1, reg2, dataWrite;
  logic          busy1, busy2, regWrite, reserve;
  logic          clearReq, clearBusy, clearDone;

  register_file_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .regs(regs), .regt(regt),
    .reg1(reg1), .reg2(reg2),
    .busy1(busy1), .busy2(busy2),
    .regWrite(regWrite), .regd(regd),
    .dataWrite(dataWrite),
    .reserve(reserve), .rsvAddr(rsvAddr),
    .clearReq(clearReq),
    .clearBusy(clearBusy), .clearDone(clearDone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic          b1;
    logic          b2;
    logic          cb;
    logic          cd;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;
  int            cb_cnt   = 0;
  int            cd_cnt   = 0;

  logic [DW-1:0] m_data[DEPTH];
  bit            m_busy[DEPTH];
  int            m_left;
  int            m_idx;

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_left = 0;
    m_idx  = 0;
    sb.delete();
  endtask

  // One clock of stimulus; the model predicts what appears after the edge.
  task automatic cyc(input logic [AW-1:0] a, input logic [AW-1:0] b,
                     input logic we, input logic [AW-1:0] d,
                     input logic [DW-1:0] w, input logic rv,
                     input logic [AW-1:0] ra, input logic cr);
    exp_t e;
    bit   wr;
    bit   rs;
    @(negedge clk);
    regs = a; regt = b; regWrite = we; regd = d;
    dataWrite = w; reserve = rv; rsvAddr = ra; clearReq = cr;
    e.r1 = m_data[a]; e.b1 = m_busy[a];
    e.r2 = m_data[b]; e.b2 = m_busy[b];
    if (m_left == 0) begin
      wr = we && (d != 0);
      rs = rv && (ra != 0);
      if (wr) begin
        m_data[d] = w;
        m_busy[d] = 1'b0;
      end
      if (rs) m_busy[ra] = 1'b1;
      if (wr && d == a) begin e.r1 = w; e.b1 = m_busy[a]; end
      if (wr && d == b) begin e.r2 = w; e.b2 = m_busy[b]; end
      e.cb = cr;
      e.cd = 1'b0;
      if (cr) begin
        m_left = DEPTH;
        m_idx  = 0;
      end
    end else begin
      m_data[m_idx] = '0;
      m_busy[m_idx] = 1'b0;
      m_idx++;
      m_left--;
      e.cb = (m_left != 0);
      e.cd = (m_left == 0);
    end
    if (a == 0) begin e.r1 = '0; e.b1 = 1'b0; end
    if (b == 0) begin e.r2 = '0; e.b2 = 1'b0; end
    sb.push_back(e);
  endtask

  task automatic idle_cyc(input logic [AW-1:0] a, input logic [AW-1:0] b);
    cyc(a, b, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    regs = '0; regt = '0; regWrite = 1'b0; regd = '0;
    dataWrite = '0; reserve = 1'b0; rsvAddr = '0; clearReq = 1'b0;
    #1;
    chk("rst_reg1", reg1, '0);
    chk("rst_reg2", reg2, '0);
    chk("rst_busy1", {31'b0, busy1}, '0);
    chk("rst_busy2", {31'b0, busy2}, '0);
    chk("rst_clearBusy", {31'b0, clearBusy}, '0);
    chk("rst_clearDone", {31'b0, clearDone}, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (clearBusy) cb_cnt++;
      if (clearDone) cd_cnt++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_reg1", reg1, e.r1);
        chk("sb_reg2", reg2, e.r2);
        chk("sb_busy1", {31'b0, busy1}, {31'b0, e.b1});
        chk("sb_busy2", {31'b0, busy2}, {31'b0, e.b2});
        chk("sb_clearBusy", {31'b0, clearBusy}, {31'b0, e.cb});
        chk("sb_clearDone", {31'b0, clearDone}, {31'b0, e.cd});
      end
    end
  end

  initial begin
    rst = 1'b1;
    regs = '0; regt = '0; regWrite = 1'b0; regd = '0;
    dataWrite = '0; reserve = 1'b0; rsvAddr = '0; clearReq = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // T1: dirty the array, then async reset and read everything back
    for (int i = 1; i < DEPTH; i++)
      cyc(AW'(i), '0, 1'b1, AW'(i), $urandom, 1'b1, AW'(i), 1'b0);
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      idle_cyc(AW'(i), AW'(DEPTH - 1 - i));

    // T2: write then read on both ports
    cyc('0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0);
    idle_cyc(5'd5, 5'd5);
    after_edge();
    chk("t2_reg1", reg1, 32'hDEADBEEF);
    chk("t2_reg2", reg2, 32'hDEADBEEF);

    // T3: same-edge write forwarded to the read
    cyc('0, '0, 1'b1, 5'd7, 32'h11, 1'b0, '0, 1'b0);
    cyc(5'd7, '0, 1'b1, 5'd7, 32'h22, 1'b0, '0, 1'b0);
    after_edge();
    chk("t3_bypass", reg1, 32'h22);

    // T4: register 0 ignores writes and reserves
    cyc('0, '0, 1'b1, '0, 32'hFFFFFFFF, 1'b1, '0, 1'b0);
    idle_cyc('0, '0);
    after_edge();
    chk("t4_r0_data", reg1, '0);
    chk("t4_r0_busy", {31'b0, busy1}, '0);

    // T5: busy scoreboard
    cyc('0, '0, 1'b0, '0, '0, 1'b1, 5'd9, 1'b0);
    idle_cyc(5'd9, '0);
    after_edge();
    chk("t5_reserved", {31'b0, busy1}, 32'd1);
    cyc(5'd9, '0, 1'b1, 5'd9, 32'h5, 1'b0, '0, 1'b0);
    after_edge();
    chk("t5_wr_busy", {31'b0, busy1}, '0);
    chk("t5_wr_data", reg1, 32'h5);
    cyc(5'd9, '0, 1'b1, 5'd9, 32'h6, 1'b1, 5'd9, 1'b0);
    idle_cyc(5'd9, '0);
    after_edge();
    chk("t5_rsv_wins", {31'b0, busy1}, 32'd1);

    // T6: full clear with writes attempted during it
    for (int i = 1; i < DEPTH; i++)
      cyc('0, '0, 1'b1, AW'(i), $urandom | 32'h1, 1'b0, '0, 1'b0);
    cb_cnt = 0;
    cd_cnt = 0;
    cyc('0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++)
      cyc(AW'($urandom), AW'($urandom), 1'b1, AW'($urandom),
          $urandom, 1'b1, AW'($urandom), 1'b0);
    idle_cyc('0, '0);
    after_edge();
    chk("t6_busy_cycles", cb_cnt, 32'd32);
    chk("t6_done_pulses", cd_cnt, 32'd1);
    for (int i = 0; i < DEPTH; i++)
      idle_cyc(AW'(i), AW'(i));

    // T6b: reset ten cycles into a clear
    for (int i = 1; i < 8; i++)
      cyc('0, '0, 1'b1, AW'(i), 32'hA5A5_0000 + i, 1'b0, '0, 1'b0);
    cyc('0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    cd_cnt = 0;
    repeat (10) idle_cyc(AW'($urandom), AW'($urandom));
    do_reset();
    for (int i = 0; i < 40; i++)
      idle_cyc(AW'(i), AW'($urandom));
    after_edge();
    chk("t6b_no_done", cd_cnt, '0);

    // Randomized traffic with collisions biased onto a few registers
    for (int n = 0; n < 1500; n++) begin
      logic [AW-1:0] a, b, d, ra;
      if ($urandom_range(0, 299) == 0) do_reset();
      a  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      b  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      d  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      ra = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      cyc(a, b, $urandom_range(0, 1) != 0, d, $urandom,
          $urandom_range(0, 3) == 0, ra, $urandom_range(0, 59) == 0);
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
